// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter that shares one BRAM read port among NUM_REQ requesters.
// One read is in flight at a time: IDLE picks a winner, ISSUE drives the address, WAIT forwards the data.
module bram_read_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_addr_valid,
  output logic [NUM_REQ-1:0]            req_addr_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_addr_valid,
  input  logic                          mem_addr_ready,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          mem_data_valid,
  output logic                          mem_data_ready,
  output logic [2:0]                    grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              last_grant_q, last_grant_d;
  logic [2:0]              grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic [2:0]              rr_start;
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic                    win_found;
  logic [2:0]              win_pos;
  logic [3:0]              win_sum;
  logic [2:0]              win_idx;
  logic [NUM_REQ-1:0]      win_oh;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    grant_resp_ready;

  // Rotate the valid vector so bit 0 is the requester right after the last grant.
  assign rr_start = (last_grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : last_grant_q + 3'd1;
  assign req_dbl  = {req_addr_valid, req_addr_valid};
  assign req_rot  = NUM_REQ'(req_dbl >> rr_start);

  always_comb begin
    win_found = 1'b0;
    win_pos   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_pos   = 3'(k);
      end
    end
  end

  assign win_sum = {1'b0, rr_start} + {1'b0, win_pos};
  assign win_idx = (win_sum >= 4'(NUM_REQ)) ? 3'(win_sum - 4'(NUM_REQ)) : win_sum[2:0];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_oh[gi]   = (win_idx == 3'(gi));
      assign grant_oh[gi] = (grant_q == 3'(gi));
    end
  endgenerate

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_addr = win_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only the granted requester's resp_ready is allowed to complete the read.
  assign grant_resp_ready = |(resp_ready & grant_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      grant_q      <= 3'd0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = ISSUE;
          grant_d = win_idx;
          addr_d  = win_addr;
        end
      end
      ISSUE: begin
        if (mem_addr_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_valid && grant_resp_ready) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_ready = '0;
    mem_addr_valid = 1'b0;
    mem_data_ready = 1'b0;
    resp_valid     = '0;
    resp_data      = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !rst) begin
          req_addr_ready = win_oh;
        end
      end
      ISSUE: mem_addr_valid = 1'b1;
      WAIT: begin
        resp_valid     = grant_oh & {NUM_REQ{mem_data_valid}};
        resp_data      = mem_data;
        mem_data_ready = grant_resp_ready;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr = addr_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: BRAM wrapper model, grant/response scoreboards,
// a table of single-transaction vectors and hand-written multi-cycle sequences.
module tb_bram_read_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_addr_valid;
  logic [N-1:0]      req_addr_ready;
  logic [DW-1:0]     resp_data;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [AW-1:0]     mem_addr;
  logic              mem_addr_valid;
  logic              mem_addr_ready;
  logic [DW-1:0]     mem_data;
  logic              mem_data_valid;
  logic              mem_data_ready;
  logic [2:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  bram_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_addr_valid(req_addr_valid), .req_addr_ready(req_addr_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready),
    .grant_id(grant_id), .busy(busy)
  );

  // BRAM wrapper model, reset together with the arbiter.
  logic [DW-1:0] bram [256];
  logic          bram_pend;
  logic [DW-1:0] bram_q;

  always @(posedge clk) begin
    if (rst) begin
      bram_pend <= 1'b0;
      bram_q    <= '0;
    end else if (!bram_pend && mem_addr_valid && mem_addr_ready) begin
      bram_pend <= 1'b1;
      bram_q    <= bram[mem_addr];
    end else if (bram_pend && mem_data_ready) begin
      bram_pend <= 1'b0;
    end
  end
  assign mem_data_valid = bram_pend;
  assign mem_data       = bram_q;

  event pre_edge;
  always @(negedge clk) begin
    #4;
    -> pre_edge;
  end

  typedef struct {
    logic [N-1:0]  valid;
    logic [AW-1:0] base;
    int            exp_id;
  } vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  int   exp_gnt_q [$];
  rsp_t exp_rsp_q [$];
  int   total = 0;
  int   bad   = 0;
  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int id);
    oh = N'(1) << id;
  endfunction

  // Called just before a rising edge: what is seen here is what the edge commits.
  task automatic mon_check();
    logic [N-1:0] ga;
    logic [N-1:0] hs;
    int           e;
    rsp_t         r;
    if (!rst) begin
      ga = req_addr_ready & req_addr_valid;
      if (|ga) begin
        if (exp_gnt_q.size() == 0) begin
          chk("grant_unexpected", 64'(ga), 64'(0));
        end else begin
          e = exp_gnt_q.pop_front();
          chk("grant_order", 64'(ga), 64'(oh(e)));
        end
      end
      hs = resp_valid & resp_ready;
      if (|hs) begin
        $display("rsp req_valid=%b data=%08h grant_id=%0d", resp_valid, resp_data, grant_id);
        if (exp_rsp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          r = exp_rsp_q.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(oh(r.id)));
          chk("resp_data", 64'(resp_data), 64'(r.data));
          chk("resp_grant_id", 64'(grant_id), 64'(r.id));
          chk("resp_mem_data_ready", 64'(mem_data_ready), 64'(1));
        end
      end
    end
  endtask

  task automatic step();
    @(pre_edge);
    mon_check();
    @(negedge clk);
  endtask

  task automatic set_addrs(input logic [AW-1:0] base);
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = base + AW'(i);
    end
  endtask

  task automatic push(input int id, input logic [AW-1:0] base, input logic with_rsp);
    rsp_t r;
    exp_gnt_q.push_back(id);
    if (with_rsp) begin
      r.id   = id;
      r.data = bram[base + AW'(id)];
      exp_rsp_q.push_back(r);
    end
  endtask

  // Run until every expected grant and response has been seen and the arbiter is idle.
  task automatic drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    if (exp_gnt_q.size() == 0) req_addr_valid = '0;
    while (!(exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && !busy) && cyc < budget) begin
      step();
      cyc++;
      if (exp_gnt_q.size() == 0) req_addr_valid = '0;
    end
    chk({name, "_timeout"}, 64'(cyc >= budget), 64'(0));
    if (cyc >= budget) begin
      exp_gnt_q.delete();
      exp_rsp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_addr_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int a = 0; a < 256; a++) bram[a] = 32'h5A5A0000 + 32'(a) * 32'h01000193;
    bram[8'h15] = 32'hDEADBEEF;

    rst            = 1'b1;
    req_addr       = '0;
    req_addr_valid = '0;
    resp_ready     = 4'b1111;
    mem_addr_ready = 1'b1;

    vt[0] = '{4'b0100, 8'h13, 2};
    vt[1] = '{4'b1111, 8'h30, 3};
    vt[2] = '{4'b0011, 8'h34, 0};
    vt[3] = '{4'b0011, 8'h38, 1};
    vt[4] = '{4'b1001, 8'h3C, 3};
    vt[5] = '{4'b0110, 8'h44, 1};
    vt[6] = '{4'b0001, 8'h48, 0};

    step();
    step();
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_mem_addr_valid", 64'(mem_addr_valid), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_mem_data_ready", 64'(mem_data_ready), 64'(0));
    chk("rst_req_addr_ready", 64'(req_addr_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table: one transaction per record, round-robin pointer carried across records.
    for (int v = 0; v < 7; v++) begin
      set_addrs(vt[v].base);
      req_addr_valid = vt[v].valid;
      push(vt[v].exp_id, vt[v].base, 1'b1);
      #1;
      chk("vec_ready", 64'(req_addr_ready), 64'(oh(vt[v].exp_id)));
      step();
      req_addr_valid = '0;
      #1;
      chk("vec_ready_one_cycle", 64'(req_addr_ready), 64'(0));
      chk("vec_mem_addr_valid", 64'(mem_addr_valid), 64'(1));
      chk("vec_mem_addr", 64'(mem_addr), 64'(vt[v].base + AW'(vt[v].exp_id)));
      chk("vec_busy", 64'(busy), 64'(1));
      drain("vec", 20);
    end

    // Fairness from reset with everyone asking.
    do_reset();
    set_addrs(8'h20);
    req_addr_valid = 4'b1111;
    for (int t = 0; t < 8; t++) push(t % N, 8'h20, 1'b1);
    drain("fair", 200);

    // Response backpressure on requester 1; requester 0 waits meanwhile.
    set_addrs(8'h40);
    resp_ready     = 4'b1101;
    req_addr_valid = 4'b0010;
    push(1, 8'h40, 1'b1);
    step();
    req_addr_valid = 4'b0001;
    push(0, 8'h40, 1'b1);
    w = 0;
    while (resp_valid[1] !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    chk("bp_wait_timeout", 64'(w >= 10), 64'(0));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'(4'b0010));
      chk("bp_resp_data", 64'(resp_data), 64'(bram[8'h41]));
      chk("bp_no_ready", 64'(req_addr_ready), 64'(0));
      chk("bp_mem_data_ready", 64'(mem_data_ready), 64'(0));
      step();
    end
    resp_ready = 4'b1111;
    drain("bp", 40);

    // Address-channel stall.
    set_addrs(8'h60);
    req_addr_valid = 4'b0100;
    push(2, 8'h60, 1'b1);
    mem_addr_ready = 1'b0;
    step();
    req_addr_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_mem_addr_valid", 64'(mem_addr_valid), 64'(1));
      chk("stall_mem_addr", 64'(mem_addr), 64'(8'h62));
      chk("stall_busy", 64'(busy), 64'(1));
      step();
    end
    mem_addr_ready = 1'b1;
    drain("stall", 20);

    // Reset while the read is waiting for its data.
    set_addrs(8'h70);
    req_addr_valid = 4'b1000;
    resp_ready     = 4'b0000;
    push(3, 8'h70, 1'b0);
    step();
    req_addr_valid = '0;
    w = 0;
    while (resp_valid[3] !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    chk("mr_wait_timeout", 64'(w >= 10), 64'(0));
    rst = 1'b1;
    step();
    #1;
    chk("mr_req_addr_ready", 64'(req_addr_ready), 64'(0));
    chk("mr_resp_valid", 64'(resp_valid), 64'(0));
    chk("mr_resp_data", 64'(resp_data), 64'(0));
    chk("mr_mem_addr", 64'(mem_addr), 64'(0));
    chk("mr_mem_addr_valid", 64'(mem_addr_valid), 64'(0));
    chk("mr_mem_data_ready", 64'(mem_data_ready), 64'(0));
    chk("mr_grant_id", 64'(grant_id), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    rst        = 1'b0;
    resp_ready = 4'b1111;
    set_addrs(8'h80);
    req_addr_valid = 4'b1001;
    push(0, 8'h80, 1'b1);
    #1;
    chk("mr_first_grant", 64'(req_addr_ready), 64'(4'b0001));
    drain("mr", 20);

    // Requester 1 pulses valid while 0 wins, then withdraws.
    set_addrs(8'h90);
    req_addr_valid = 4'b1000;
    push(3, 8'h90, 1'b1);
    drain("wd_pre", 20);
    req_addr_valid = 4'b0011;
    push(0, 8'h90, 1'b1);
    #1;
    chk("wd_ready", 64'(req_addr_ready), 64'(4'b0001));
    step();
    req_addr_valid = '0;
    drain("wd", 20);
    for (int k = 0; k < 4; k++) step();
    chk("queues_empty", 64'(exp_gnt_q.size() + exp_rsp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
